// File: rtl/ahb_rr_arbiter_if.sv
// Arbitration-side AHB signals shared between the masters/mux and the round-robin arbiter.
// Port names follow the AHB signal names used throughout the interconnect.
interface ahb_rr_arbiter_if #(
  parameter int unsigned NUM_M = 4
);
  logic [NUM_M-1:0] HBUSREQ;
  logic [NUM_M-1:0] HLOCK;
  logic [1:0]       HTRANS;
  logic [2:0]       HBURST;
  logic             HREADY;
  logic [1:0]       HRESP;
  logic [NUM_M-1:0] HGRANT;
  logic [3:0]       HMASTER;
  logic [3:0]       HMASTERD;
  logic             HMASTLOCK;

  // Bus side: masters and muxed slave response drive the arbiter inputs
  modport master (
    output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP,
    input  HGRANT, HMASTER, HMASTERD, HMASTLOCK
  );

  // Arbiter side
  modport slave (
    input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP,
    output HGRANT, HMASTER, HMASTERD, HMASTLOCK
  );
endinterface

// File: rtl/ahb_rr_arbiter.sv
// Round-robin AHB arbiter: rotates the address bus among NUM_M masters without
// breaking fixed-length or locked bursts; all outputs come straight from flops.
module ahb_rr_arbiter #(
  parameter int unsigned NUM_M     = 4,
  parameter int unsigned DEFAULT_M = 0
) (
  input  logic          HCLK,
  input  logic          HRESET,
  ahb_rr_arbiter_if.slave bus
);
  localparam int unsigned IW = (NUM_M > 2) ? 2 : 1;
  localparam int unsigned BW = 5;

  localparam logic [1:0] TR_IDLE   = 2'd0;
  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FIX  = 2'd1,
    S_INCR = 2'd2,
    S_LOCK = 2'd3
  } state_t;

  state_t           state_q, state_n, nonseq_target;
  logic [BW-1:0]    beats_left, beats_n, burst_len;
  logic [IW-1:0]    grant_idx, last_idx, own_idx, win_idx, cand;
  logic             win_found;
  logic [NUM_M-1:0] win_onehot;
  logic [NUM_M-1:0] hgrant_q;
  logic [3:0]       hmaster_q, hmasterd_q;
  logic             hmastlock_q;
  logic             acc_nonseq, acc_seq, err, own_req, own_lock, arb_ok;

  assign own_idx    = hmaster_q[IW-1:0];
  assign own_req    = bus.HBUSREQ[own_idx];
  assign own_lock   = bus.HLOCK[own_idx];
  assign acc_nonseq = bus.HREADY && (bus.HTRANS == TR_NONSEQ);
  assign acc_seq    = bus.HREADY && (bus.HTRANS == TR_SEQ);
  assign err        = bus.HREADY && (bus.HRESP != 2'd0);

  // Burst length in beats; 0 marks an undefined-length INCR
  always_comb begin
    burst_len = 5'd16;
    case (bus.HBURST)
      3'd0:       burst_len = 5'd1;
      3'd1:       burst_len = 5'd0;
      3'd2, 3'd3: burst_len = 5'd4;
      3'd4, 3'd5: burst_len = 5'd8;
      default:    burst_len = 5'd16;
    endcase
  end

  always_comb begin
    nonseq_target = S_IDLE;
    if (own_lock)                nonseq_target = S_LOCK;
    else if (burst_len > 5'd1)   nonseq_target = S_FIX;
    else if (burst_len == 5'd0)  nonseq_target = S_INCR;
  end

  // Next state and beat counter
  always_comb begin
    state_n = state_q;
    beats_n = beats_left;
    if (acc_nonseq)                          beats_n = burst_len - 5'd1;
    else if (acc_seq && beats_left != 5'd0)  beats_n = beats_left - 5'd1;

    case (state_q)
      S_IDLE: if (acc_nonseq) state_n = nonseq_target;
      S_FIX: begin
        if (acc_nonseq)                           state_n = nonseq_target;
        else if (acc_seq && beats_left == 5'd1)   state_n = S_IDLE;
      end
      S_INCR: begin
        if (acc_nonseq) state_n = nonseq_target;
        else if (bus.HREADY && (!own_req || bus.HTRANS == TR_IDLE)) state_n = S_IDLE;
      end
      S_LOCK: if (bus.HREADY && !own_lock && bus.HTRANS == TR_IDLE) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    // A non-OKAY response abandons the burst (SPLIT handled as RETRY)
    if (err) begin
      state_n = S_IDLE;
      beats_n = '0;
    end
  end

  assign arb_ok = bus.HREADY &&
                  ((state_n == S_IDLE) || (state_q == S_IDLE && !acc_nonseq));

  // Round-robin search starting just after the last real winner
  always_comb begin
    win_found = 1'b0;
    win_idx   = IW'(DEFAULT_M);
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_M; k++) begin
      cand = IW'((32'(last_idx) + k) % NUM_M);
      if (!win_found && bus.HBUSREQ[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    win_onehot          = '0;
    win_onehot[win_idx] = 1'b1;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= S_IDLE;
      beats_left  <= '0;
      grant_idx   <= IW'(DEFAULT_M);
      last_idx    <= IW'(DEFAULT_M);
      hgrant_q    <= NUM_M'(1) << DEFAULT_M;
      hmaster_q   <= 4'(DEFAULT_M);
      hmasterd_q  <= 4'(DEFAULT_M);
      hmastlock_q <= 1'b0;
    end else if (bus.HREADY) begin
      state_q     <= state_n;
      beats_left  <= beats_n;
      hmaster_q   <= 4'(grant_idx);
      hmasterd_q  <= hmaster_q;
      hmastlock_q <= bus.HLOCK[grant_idx];
      if (arb_ok) begin
        grant_idx <= win_idx;
        hgrant_q  <= win_onehot;
        if (win_found) last_idx <= win_idx;
      end
    end
  end

  assign bus.HGRANT    = hgrant_q;
  assign bus.HMASTER   = hmaster_q;
  assign bus.HMASTERD  = hmasterd_q;
  assign bus.HMASTLOCK = hmastlock_q;
endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Directed self-checking bench for ahb_rr_arbiter (NUM_M=4, DEFAULT_M=0).
module tb_ahb_rr_arbiter;
  localparam int unsigned NUM_M = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ahb_rr_arbiter_if #(.NUM_M(NUM_M)) bus ();

  ahb_rr_arbiter #(.NUM_M(NUM_M), .DEFAULT_M(0)) dut (
    .HCLK  (clk),
    .HRESET(rst),
    .bus   (bus.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.HBUSREQ = '0;
    bus.HLOCK   = '0;
    bus.HTRANS  = 2'd0;
    bus.HBURST  = 3'd0;
    bus.HREADY  = 1'b1;
    bus.HRESP   = 2'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    for (int e = 1; e <= 2; e++) begin
      step();
      checks++; if (bus.HGRANT !== 4'b0001) begin failures++; $display("FAIL reset_hgrant edge%0d got=%b want=0001", e, bus.HGRANT); end
      checks++; if (bus.HMASTER !== 4'd0) begin failures++; $display("FAIL reset_hmaster edge%0d got=%0d want=0", e, bus.HMASTER); end
      checks++; if (bus.HMASTERD !== 4'd0) begin failures++; $display("FAIL reset_hmasterd edge%0d got=%0d want=0", e, bus.HMASTERD); end
      checks++; if (bus.HMASTLOCK !== 1'b0) begin failures++; $display("FAIL reset_hmastlock edge%0d got=%b want=0", e, bus.HMASTLOCK); end
    end
    rst = 1'b0;
  endtask

  task automatic test_rotation();
    int          exp_g [6] = '{1, 2, 3, 1, 2, 3};
    logic [3:0]  exp_m = 4'd0, exp_d = 4'd0, prev_g = 4'd0;
    logic [3:0]  exp_oh;
    do_reset();
    bus.HBUSREQ = 4'b1110;
    bus.HTRANS  = 2'd2;
    bus.HBURST  = 3'd0;
    for (int i = 0; i < 6; i++) begin
      step();
      exp_d  = exp_m;
      exp_m  = prev_g;
      prev_g = 4'(exp_g[i]);
      exp_oh = 4'b0001 << exp_g[i];
      checks++; if (bus.HGRANT !== exp_oh) begin failures++; $display("FAIL rot_hgrant step%0d got=%b want=%b", i, bus.HGRANT, exp_oh); end
      checks++; if (bus.HMASTER !== exp_m) begin failures++; $display("FAIL rot_hmaster step%0d got=%0d want=%0d", i, bus.HMASTER, exp_m); end
      checks++; if (bus.HMASTERD !== exp_d) begin failures++; $display("FAIL rot_hmasterd step%0d got=%0d want=%0d", i, bus.HMASTERD, exp_d); end
    end
    idle_inputs();
  endtask

  task automatic test_incr8();
    logic [3:0] want;
    do_reset();
    bus.HBUSREQ = 4'b0100;
    step();
    checks++; if (bus.HGRANT !== 4'b0100) begin failures++; $display("FAIL incr8_grant_m2 got=%b want=0100", bus.HGRANT); end
    step();
    checks++; if (bus.HMASTER !== 4'd2) begin failures++; $display("FAIL incr8_owner got=%0d want=2", bus.HMASTER); end
    bus.HBUSREQ = 4'b1100;
    bus.HTRANS  = 2'd2;
    bus.HBURST  = 3'd5;
    step();
    checks++; if (bus.HGRANT !== 4'b0100) begin failures++; $display("FAIL incr8_nonseq_no_preempt got=%b want=0100", bus.HGRANT); end
    for (int b = 2; b <= 8; b++) begin
      bus.HTRANS = 2'd3;
      if (b == 4) begin
        bus.HREADY = 1'b0;
        for (int w = 0; w < 2; w++) begin
          step();
          checks++; if (bus.HGRANT !== 4'b0100) begin failures++; $display("FAIL incr8_wait_grant w%0d got=%b want=0100", w, bus.HGRANT); end
          checks++; if (bus.HMASTER !== 4'd2) begin failures++; $display("FAIL incr8_wait_hmaster w%0d got=%0d want=2", w, bus.HMASTER); end
        end
        bus.HREADY = 1'b1;
      end
      step();
      want = (b == 8) ? 4'b1000 : 4'b0100;
      checks++; if (bus.HGRANT !== want) begin failures++; $display("FAIL incr8_beat_grant beat%0d got=%b want=%b", b, bus.HGRANT, want); end
    end
    checks++; if (dut.beats_left !== 5'd0) begin failures++; $display("FAIL incr8_beats_left got=%0d want=0", dut.beats_left); end
    checks++; if (dut.state_q !== 2'd0) begin failures++; $display("FAIL incr8_state got=%0d want=0", dut.state_q); end
    bus.HTRANS = 2'd0;
    step();
    checks++; if (bus.HMASTER !== 4'd3) begin failures++; $display("FAIL incr8_handover_hmaster got=%0d want=3", bus.HMASTER); end
    checks++; if (bus.HMASTERD !== 4'd2) begin failures++; $display("FAIL incr8_handover_hmasterd got=%0d want=2", bus.HMASTERD); end
    idle_inputs();
  endtask

  task automatic test_lock();
    do_reset();
    bus.HBUSREQ = 4'b1000;
    bus.HLOCK   = 4'b1000;
    step();
    checks++; if (bus.HGRANT !== 4'b1000) begin failures++; $display("FAIL lock_grant_m3 got=%b want=1000", bus.HGRANT); end
    checks++; if (bus.HMASTLOCK !== 1'b0) begin failures++; $display("FAIL lock_mastlock_pre got=%b want=0", bus.HMASTLOCK); end
    step();
    checks++; if (bus.HMASTLOCK !== 1'b1) begin failures++; $display("FAIL lock_mastlock_on got=%b want=1", bus.HMASTLOCK); end
    bus.HBUSREQ = 4'b1100;
    bus.HTRANS  = 2'd2;
    bus.HBURST  = 3'd3;
    step();
    checks++; if (dut.state_q !== 2'd3) begin failures++; $display("FAIL lock_state got=%0d want=3", dut.state_q); end
    // INCR4 remaining beats, then a SINGLE, then an IDLE while HLOCK still held
    for (int s = 0; s < 5; s++) begin
      bus.HTRANS = (s < 3) ? 2'd3 : ((s == 3) ? 2'd2 : 2'd0);
      bus.HBURST = (s == 3) ? 3'd0 : 3'd3;
      step();
      checks++; if (bus.HGRANT !== 4'b1000) begin failures++; $display("FAIL lock_hold_grant s%0d got=%b want=1000", s, bus.HGRANT); end
      checks++; if (bus.HMASTLOCK !== 1'b1) begin failures++; $display("FAIL lock_hold_mastlock s%0d got=%b want=1", s, bus.HMASTLOCK); end
    end
    bus.HLOCK  = 4'b0000;
    bus.HTRANS = 2'd0;
    step();
    checks++; if (bus.HGRANT !== 4'b0100) begin failures++; $display("FAIL lock_release_grant got=%b want=0100", bus.HGRANT); end
    checks++; if (bus.HMASTLOCK !== 1'b0) begin failures++; $display("FAIL lock_release_mastlock got=%b want=0", bus.HMASTLOCK); end
    idle_inputs();
  endtask

  task automatic test_error();
    do_reset();
    bus.HBUSREQ = 4'b0100;
    step();
    step();
    bus.HBUSREQ = 4'b1100;
    bus.HTRANS  = 2'd2;
    bus.HBURST  = 3'd7;
    step();
    checks++; if (dut.state_q !== 2'd1) begin failures++; $display("FAIL err_state_fix got=%0d want=1", dut.state_q); end
    for (int b = 2; b <= 5; b++) begin
      bus.HTRANS = 2'd3;
      step();
      checks++; if (bus.HGRANT !== 4'b0100) begin failures++; $display("FAIL err_pre_grant beat%0d got=%b want=0100", b, bus.HGRANT); end
    end
    // First RETRY cycle has HREADY low: nothing may change
    bus.HRESP  = 2'd2;
    bus.HREADY = 1'b0;
    step();
    checks++; if (bus.HGRANT !== 4'b0100) begin failures++; $display("FAIL err_wait_grant got=%b want=0100", bus.HGRANT); end
    checks++; if (dut.beats_left !== 5'd11) begin failures++; $display("FAIL err_wait_beats got=%0d want=11", dut.beats_left); end
    bus.HREADY = 1'b1;
    step();
    checks++; if (bus.HGRANT !== 4'b1000) begin failures++; $display("FAIL err_abort_grant got=%b want=1000", bus.HGRANT); end
    checks++; if (dut.state_q !== 2'd0) begin failures++; $display("FAIL err_abort_state got=%0d want=0", dut.state_q); end
    checks++; if (dut.beats_left !== 5'd0) begin failures++; $display("FAIL err_abort_beats got=%0d want=0", dut.beats_left); end
    idle_inputs();
  endtask

  task automatic test_no_requesters();
    do_reset();
    bus.HBUSREQ = 4'b0010;
    step();
    step();
    bus.HBUSREQ = 4'b0000;
    bus.HTRANS  = 2'd2;
    bus.HBURST  = 3'd0;
    step();
    checks++; if (bus.HGRANT !== 4'b0001) begin failures++; $display("FAIL noreq_grant got=%b want=0001", bus.HGRANT); end
    checks++; if (dut.last_idx !== 2'd1) begin failures++; $display("FAIL noreq_last_idx got=%0d want=1", dut.last_idx); end
    bus.HTRANS = 2'd0;
    step();
    checks++; if (bus.HMASTER !== 4'd0) begin failures++; $display("FAIL noreq_hmaster got=%0d want=0", bus.HMASTER); end
    checks++; if (bus.HMASTERD !== 4'd1) begin failures++; $display("FAIL noreq_hmasterd got=%0d want=1", bus.HMASTERD); end
    idle_inputs();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    bus.HBUSREQ = 4'b0100;
    bus.HLOCK   = 4'b0100;
    step();
    step();
    bus.HTRANS = 2'd2;
    bus.HBURST = 3'd5;
    step();
    bus.HTRANS = 2'd3;
    step();
    checks++; if (bus.HMASTLOCK !== 1'b1) begin failures++; $display("FAIL midrst_pre_mastlock got=%b want=1", bus.HMASTLOCK); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (bus.HGRANT !== 4'b0001) begin failures++; $display("FAIL midrst_hgrant got=%b want=0001", bus.HGRANT); end
    checks++; if (bus.HMASTER !== 4'd0) begin failures++; $display("FAIL midrst_hmaster got=%0d want=0", bus.HMASTER); end
    checks++; if (bus.HMASTERD !== 4'd0) begin failures++; $display("FAIL midrst_hmasterd got=%0d want=0", bus.HMASTERD); end
    checks++; if (bus.HMASTLOCK !== 1'b0) begin failures++; $display("FAIL midrst_hmastlock got=%b want=0", bus.HMASTLOCK); end
    checks++; if (dut.beats_left !== 5'd0) begin failures++; $display("FAIL midrst_beats got=%0d want=0", dut.beats_left); end
    checks++; if (dut.state_q !== 2'd0) begin failures++; $display("FAIL midrst_state got=%0d want=0", dut.state_q); end
    checks++; if (dut.last_idx !== 2'd0) begin failures++; $display("FAIL midrst_last_idx got=%0d want=0", dut.last_idx); end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_rotation();
    test_incr8();
    test_lock();
    test_error();
    test_no_requesters();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ahb_rr_arbiter.md
# ahb_rr_arbiter

Round-robin AHB bus arbiter for the shared master-to-slave interconnect. It decides which of up to four masters owns the address bus, based on `HBUSREQ`, `HLOCK`, burst progress and slave responses. It drives the one-hot grant vector to the masters and to the m2s multiplexer, the address-phase owner (`HMASTER`), the data-phase owner (`HMASTERD`) and `HMASTLOCK`. It replaces fixed-priority selection with fair rotation that never breaks a fixed-length or locked burst.

## Interface
- `NUM_M`, 4: number of masters, 2..4.
- `DEFAULT_M`, 0: master granted when nobody requests (it must drive IDLE).
- `HCLK` in 1: bus clock; all state updates on the rising edge.
- `HRESET` in 1: reset, synchronous, active-high.
- `HBUSREQ` in NUM_M: per-master bus request.
- `HLOCK` in NUM_M: per-master locked-transfer request.
- `HTRANS` in 2: muxed transfer type from the current owner (0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ).
- `HBURST` in 3: muxed burst type (0 SINGLE, 1 INCR, 2/3 WRAP4/INCR4, 4/5 WRAP8/INCR8, 6/7 WRAP16/INCR16).
- `HREADY` in 1: muxed slave ready.
- `HRESP` in 2: muxed slave response (0 OKAY, 1 ERROR, 2 RETRY, 3 SPLIT).
- `HGRANT` out NUM_M: one-hot grant.
- `HMASTER` out 4: address-phase owner index.
- `HMASTERD` out 4: data-phase owner index.
- `HMASTLOCK` out 1: the current address phase belongs to a locked sequence.

## Operation
- **Registers.** `grant_idx`, `last_idx`, `beats_left` (5 bits), state.
- **States.**
  - `S_IDLE`: the owner is not in a burst.
  - `S_FIX`: the owner is in a fixed-length burst.
  - `S_INCR`: the owner is in an undefined-length INCR burst.
  - `S_LOCK`: the owner holds `HLOCK`.
- **Accepted transfer.** An accepted transfer is any rising edge with `HREADY`=1 and `HTRANS` NONSEQ or SEQ.
- **Beat counting.**
  - On an accepted NONSEQ, `beats_left` loads `len-1`. `len` is 1 for SINGLE, 4, 8 or 16 for fixed bursts, and 0 for INCR.
  - On an accepted SEQ, `beats_left` decrements and saturates at 0.
  - BUSY and IDLE do not change `beats_left`.
- **Transitions.**
  - Accepted NONSEQ with `HLOCK[HMASTER]`=1 moves to `S_LOCK`, whatever the burst type.
  - Otherwise, accepted NONSEQ moves to `S_FIX` if `len`>1, to `S_INCR` if INCR, and stays in `S_IDLE` for SINGLE.
  - `S_FIX` returns to `S_IDLE` when the accepted transfer has `beats_left`=1 before the decrement (the last beat).
  - `S_INCR` returns to `S_IDLE` when `HBUSREQ[HMASTER]`=0 or `HTRANS`=IDLE, in each case with `HREADY`=1.
  - `S_LOCK` returns to `S_IDLE` when `HLOCK[HMASTER]`=0 and `HTRANS`=IDLE with `HREADY`=1.
  - In any state, a data-phase `HRESP`≠OKAY with `HREADY`=1 forces `S_IDLE` and `beats_left`=0. SPLIT is treated as RETRY.
- **Arbitration window.** Arbitration is allowed on a rising edge with `HREADY`=1 when either of these holds:
  - the next state is `S_IDLE`;
  - the state is `S_IDLE` and no accepted NONSEQ occurs this edge.
- **Round-robin selection.**
  - Search `HBUSREQ` starting at `(last_idx+1) mod NUM_M` and wrap around.
  - The first requester wins. If there is no requester, the winner is `DEFAULT_M`.
  - `grant_idx` takes the winner and `HGRANT` becomes the winner's one-hot code.
  - `last_idx` updates only when a real requester wins.
  - If the current owner still requests and no other master requests, it keeps the grant.
- **Ownership pipeline.**
  - `HMASTER` takes `grant_idx` on every edge with `HREADY`=1.
  - `HMASTERD` takes `HMASTER` on every edge with `HREADY`=1.
  - `HMASTLOCK` takes `HLOCK[grant_idx]` together with `HMASTER`.
- **`HREADY`=0.** All registers hold and outputs are frozen.
- **Reset** (a `HCLK` edge with `HRESET`=1) sets:
  - `HGRANT` = one-hot(`DEFAULT_M`);
  - `HMASTER` = `HMASTERD` = `last_idx` = `DEFAULT_M`;
  - `HMASTLOCK` = 0, `beats_left` = 0, state = `S_IDLE`.
- **Reset mid-burst** aborts immediately. No completion of outstanding beats is attempted.

## Timing
- **Grant latency.** A request seen at edge E while arbitration is allowed gives `HGRANT` valid after E. `HMASTER` follows on the next `HREADY`=1 edge (E+1 if there are no waits). `HMASTERD` follows one `HREADY` edge after that.
- **Fixed bursts.** The grant moves on the edge that accepts the last beat's address. The new owner's NONSEQ address appears after `HMASTER` updates, which gives one handover cycle in which the old owner drives IDLE.
- **Simultaneous events.**
  - A request arriving on the same edge the owner issues a NONSEQ does not pre-empt the owner.
  - An error response on the same edge as an accepted transfer takes priority, so the state goes to `S_IDLE`.
- **Stability.** Outputs are glitch-free: all are direct flop outputs.

## Test plan
- **Reset.** Hold `HRESET`=1 for 2 cycles with `DEFAULT_M`=0 → `HGRANT`=0001, `HMASTER`=`HMASTERD`=0, `HMASTLOCK`=0 from the first edge.
- **Rotation.** Masters 1, 2 and 3 request continuously with SINGLE transfers and `HREADY`=1 → grants rotate 1→2→3→1, `HMASTER` lags the grant by 1 cycle, `HMASTERD` lags by 2.
- **INCR8 protection.** Master 2 issues INCR8 with 2 wait states on beat 4 while master 3 requests → `HGRANT` stays 0100 until the edge accepting beat 8, then becomes 1000. No beat is lost and `beats_left` is 0 at the end.
- **Lock.** Master 3 asserts `HBUSREQ`+`HLOCK` and does INCR4 then SINGLE while master 2 requests → the grant stays with 3 and `HMASTLOCK`=1 for the whole sequence. The grant passes to 2 only after `HLOCK[3]`=0 and `HTRANS`=IDLE.
- **Abort on error.** Master 2 runs INCR16 and a RETRY arrives on beat 5 with master 3 requesting → state goes to `S_IDLE` and `HGRANT`=1000 on that `HREADY` edge.
- **No requesters.** Drop all requests → after the current transfer, `HGRANT`=one-hot(`DEFAULT_M`) and `last_idx` is unchanged. A reset asserted mid-burst restores all reset values on the next edge.
